// File: rtl/i2s_master_rx.sv
// i2s_master_rx
//   I2S bus-master receiver. Generates the bit clock (clk_i/2) and word
//   select, deserialises MSB-first words from a slave transmitter and
//   presents each completed left/right word with a one-cycle write strobe.
//
// Parameters
//   WORD_WIDTH  bits per channel word (2..32)
//
// Ports
//   clk_i      in   system clock, rising edge
//   rst_i      in   asynchronous reset, active low
//   data_o     out  last completed word, MSB = first bit received
//   lr_chnl_o  out  channel of data_o (0 = left, 1 = right)
//   write_o    out  one-cycle strobe, data_o/lr_chnl_o valid while high
//   sclk_o     out  I2S bit clock
//   wsel_o     out  I2S word select (0 = left, 1 = right)
//   sdat_i     in   I2S serial data, launched by the slave on falling sclk_o
//
// Build option
//   I2S_RX_SKIP_FIRST_FRAME_EN  when defined, write_o is suppressed for both
//   words of the first frame after reset release; data_o/lr_chnl_o still
//   update. When undefined, every word is strobed.

module i2s_master_rx #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  lr_chnl_o,
  output logic                  write_o,
  output logic                  sclk_o,
  output logic                  wsel_o,
  input  logic                  sdat_i
);

  localparam int CW = $clog2(2 * WORD_WIDTH);

  localparam logic [CW-1:0] SLOT_LAST_L = CW'(WORD_WIDTH - 1);
  localparam logic [CW-1:0] SLOT_LAST_R = CW'(2 * WORD_WIDTH - 1);
  localparam logic [CW-1:0] SLOT_PRE_L  = CW'(WORD_WIDTH - 2);
  localparam logic [CW-1:0] SLOT_PRE_R  = CW'(2 * WORD_WIDTH - 2);

  logic [CW-1:0]         cnt;
  logic [WORD_WIDTH-1:0] shift_q;
  logic                  rise_edge;
  logic                  fall_edge;
  logic                  word_end;
  logic                  strobe_en;

  // sclk_o low now means this edge drives it high (sample point); high
  // means this edge drives it low (slot boundary).
  assign rise_edge = ~sclk_o;
  assign fall_edge = sclk_o;

  // The last sample of a word happened on the previous edge, so the word is
  // complete on the falling edge that closes slot W-1 or 2W-1.
  assign word_end  = fall_edge && ((cnt == SLOT_LAST_L) || (cnt == SLOT_LAST_R));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sclk_o <= 1'b0;
    end else begin
      sclk_o <= ~sclk_o;
    end
  end

  // Slot counter and word select. wsel_o leads the data by one slot, so it
  // changes when entering the last slot of the opposite channel.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt    <= '0;
      wsel_o <= 1'b0;
    end else if (fall_edge) begin
      cnt <= (cnt == SLOT_LAST_R) ? '0 : cnt + CW'(1);
      if (cnt == SLOT_PRE_L) begin
        wsel_o <= 1'b1;
      end else if (cnt == SLOT_PRE_R) begin
        wsel_o <= 1'b0;
      end
    end
  end

  // sdat_i shares the clk_i domain through sclk_o, so it is sampled directly.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shift_q <= '0;
    end else if (rise_edge) begin
      shift_q <= {shift_q[WORD_WIDTH-2:0], sdat_i};
    end
  end

`ifdef I2S_RX_SKIP_FIRST_FRAME_EN
  // The slave may not be word-aligned during the first frame after reset,
  // so neither of its words is strobed.
  logic first_frame;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      first_frame <= 1'b1;
    end else if (fall_edge && (cnt == SLOT_LAST_R)) begin
      first_frame <= 1'b0;
    end
  end

  assign strobe_en = ~first_frame;
`else
  assign strobe_en = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_o    <= '0;
      lr_chnl_o <= 1'b0;
      write_o   <= 1'b0;
    end else begin
      write_o <= 1'b0;
      if (word_end) begin
        data_o    <= shift_q;
        lr_chnl_o <= (cnt == SLOT_LAST_R);
        write_o   <= strobe_en;
      end
    end
  end

endmodule

// File: tb/tb_i2s_master_rx.sv
// tb_i2s_master_rx
//   Self-checking bench for i2s_master_rx (WORD_WIDTH = 16). A slave model
//   serialises a table of words from the bench's own edge count; expected
//   bus and strobe behaviour is computed from edge arithmetic.

module tb_i2s_master_rx;

  localparam int W    = 16;
  localparam int NW   = 32;

  logic         clk_i  = 1'b0;
  logic         rst_i  = 1'b0;
  logic         sdat_i = 1'b0;
  logic [W-1:0] data_o;
  logic         lr_chnl_o;
  logic         write_o;
  logic         sclk_o;
  logic         wsel_o;

  always #5 clk_i = ~clk_i;

  i2s_master_rx #(.WORD_WIDTH(W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .data_o    (data_o),
    .lr_chnl_o (lr_chnl_o),
    .write_o   (write_o),
    .sclk_o    (sclk_o),
    .wsel_o    (wsel_o),
    .sdat_i    (sdat_i)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  int           n        = 0;
  logic [W-1:0] words [0:NW-1];
  logic [W-1:0] exp_data;
  logic         exp_lr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_data"},  32'(data_o),    32'h0);
    check_val({tag, "_lr"},    32'(lr_chnl_o), 32'h0);
    check_val({tag, "_write"}, 32'(write_o),   32'h0);
    check_val({tag, "_sclk"},  32'(sclk_o),    32'h0);
    check_val({tag, "_wsel"},  32'(wsel_o),    32'h0);
  endtask

  // Slave: bit of slot k is word (k / W), bit W-1-(k mod W).
  task automatic drive_slot();
    int k;
    int j;
    k = n / 2;
    j = k / W;
    if (j < NW) sdat_i = words[j][W-1-(k%W)];
    else        sdat_i = 1'b0;
  endtask

  task automatic fill_random(input int first);
    for (int i = first; i < NW; i++) words[i] = W'($urandom);
  endtask

  task automatic start_run();
    n        = 0;
    exp_data = '0;
    exp_lr   = 1'b0;
    drive_slot();
  endtask

  task automatic step();
    int   slot;
    int   j;
    logic exp_wr;
    logic exp_ws;
    @(posedge clk_i);
    n++;
    #1;
    slot   = n / 2;
    exp_wr = 1'b0;
    if ((n % (2*W)) == 0) begin
      j        = n / (2*W) - 1;
      exp_data = words[j];
      exp_lr   = ((j % 2) == 1);
      exp_wr   = 1'b1;
`ifdef I2S_RX_SKIP_FIRST_FRAME_EN
      if (n <= 4*W) exp_wr = 1'b0;
`endif
    end
    exp_ws = (((slot + 1) % (2*W)) >= W);
    check_val("sclk",  32'(sclk_o),    32'(n % 2));
    check_val("wsel",  32'(wsel_o),    32'(exp_ws));
    check_val("write", 32'(write_o),   32'(exp_wr));
    check_val("data",  32'(data_o),    32'(exp_data));
    check_val("lr",    32'(lr_chnl_o), 32'(exp_lr));
    if ((n % 2) == 0) drive_slot();
  endtask

  initial begin
    // Frame table: fixed pattern twice, all ones, all zeros, then random.
    fill_random(0);
    words[0] = 16'hA5C3; words[1] = 16'h1234;
    words[2] = 16'hA5C3; words[3] = 16'h1234;
    words[4] = 16'hFFFF; words[5] = 16'hFFFF;
    words[6] = 16'h0000; words[7] = 16'h0000;

    rst_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i);
      #1;
      check_reset("hold");
    end

    @(negedge clk_i);
    rst_i = 1'b1;
    start_run();
    repeat (6 * 4 * W) step();

    // Reset after a completed word: outputs clear at once.
    rst_i = 1'b0;
    #1;
    check_reset("rst_end");

    @(negedge clk_i);
    rst_i = 1'b1;
    fill_random(0);
    start_run();
    repeat (20) step();

    // Reset mid-frame, held for 3 cycles; partial word is discarded.
    rst_i = 1'b0;
    #1;
    check_reset("rst_mid");
    repeat (3) begin
      @(posedge clk_i);
      #1;
      check_reset("rst_mid_hold");
    end

    @(negedge clk_i);
    rst_i = 1'b1;
    fill_random(0);
    start_run();
    repeat (3 * 4 * W) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
